// File: rtl/fifo_pkg.sv
// Shared types and line levels for the FIFO drain-side serial transmitter.
package fifo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/fifo_serial_tx_bit_tick.sv
// Free-running mod-CLKS_PER_BIT bit timer; tick marks the terminal count.
module bit_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  assign tick = (cnt_q == LAST);
  // tick_next lets the owner register outputs that must coincide with tick.
  assign tick_next = (cnt_d == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pulls words from the FIFO read port and sends each as a start/LSB-first/stop frame.
module fifo_serial_tx
  import fifo_pkg::*;
#(
  parameter int DATO_WIDTH   = 3,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empy,
  input  logic [DATO_WIDTH-1:0] fifo_datout,
  output logic                  fifo_rclk,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = $clog2(DATO_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATO_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATO_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  rclk_q, rclk_d;
  logic                  done_q, done_d;
  logic                  tick, tick_next, timer_clr;

  assign timer_clr = (state_d != state_q);

  bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .tick     (tick),
    .tick_next(tick_next)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (en && !fifo_empy) begin
          state_d = READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        shreg_d = fifo_datout;
        state_d = START;
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            state_d   = STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = (en && !fifo_empy) ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the registered pins line up with the state.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
    rclk_d = (state_d == READ);
    done_d = (state_d == STOP) && tick_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      rclk_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      rclk_q    <= rclk_d;
      done_q    <= done_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign fifo_rclk = rclk_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Self-checking bench: FIFO model plus frame-level scoreboard of the recorded line trace.
module tb_fifo_serial_tx;

  localparam int W     = 3;
  localparam int CPB   = 4;
  localparam int FRAME = (W + 2) * CPB;
  localparam int WIN   = FRAME + 2;
  localparam int TMAX  = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         fifo_empy;
  logic [W-1:0] fifo_datout;
  logic         fifo_rclk;
  logic         tx;
  logic         busy;
  logic         done;

  fifo_serial_tx #(
    .DATO_WIDTH  (W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empy  (fifo_empy),
    .fifo_datout(fifo_datout),
    .fifo_rclk  (fifo_rclk),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int unsigned  n_vec = 0;
  int unsigned  n_bad = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int           pulse_pos[$];
  logic         tr_tx[TMAX];
  logic         tr_busy[TMAX];
  logic         tr_rclk[TMAX];
  logic         tr_done[TMAX];
  int           tcnt;
  bit           hold;
  bit           toggle;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    fifo_empy = 1'b0;
  endtask

  // One clock: sample the line mid-cycle, then act as the FIFO read port.
  task automatic step();
    @(negedge clk);
    if (tcnt < TMAX) begin
      tr_tx[tcnt]   = tx;
      tr_busy[tcnt] = busy;
      tr_rclk[tcnt] = fifo_rclk;
      tr_done[tcnt] = done;
      tcnt++;
    end
    if (fifo_rclk) begin
      check_eq("read_when_empty", 32'(fq.size() == 0), 0);
      if (fq.size() != 0) fifo_datout = fq.pop_front();
      hold = 1'b1;
    end else if (hold) begin
      hold = 1'b0;
    end else if (toggle) begin
      fifo_datout = W'($urandom);
    end
    fifo_empy = (fq.size() == 0);
  endtask

  function automatic logic frame_bit(input logic [W-1:0] w, input int j);
    logic [W-1:0] v;
    v = w;
    if (j < CPB) return 1'b0;
    if (j >= (W + 1) * CPB) return 1'b1;
    return v[j / CPB - 1];
  endfunction

  // Walks the trace: each read pulse must open a full frame carrying the next expected word.
  task automatic analyze(input string tag, input int first_at);
    int t;
    logic [W-1:0] w;
    logic eb;
    pulse_pos.delete();
    t = 0;
    while (t < tcnt) begin
      if (tr_rclk[t]) begin
        pulse_pos.push_back(t);
        if (exp_q.size() == 0) begin
          check_eq({tag, "_extra_read"}, 1, 0);
          t++;
        end else if (t + WIN > tcnt) begin
          check_eq({tag, "_truncated"}, 32'(t + WIN), 32'(tcnt));
          t = tcnt;
        end else begin
          w = exp_q.pop_front();
          for (int i = 0; i < WIN; i++) begin
            eb = (i < 2) ? 1'b1 : frame_bit(w, i - 2);
            check_eq({tag, "_tx"},   32'(tr_tx[t+i]),   32'(eb));
            check_eq({tag, "_busy"}, 32'(tr_busy[t+i]), 1);
            check_eq({tag, "_rclk"}, 32'(tr_rclk[t+i]), 32'(i == 0));
            check_eq({tag, "_done"}, 32'(tr_done[t+i]), 32'(i == WIN - 1));
          end
          t += WIN;
        end
      end else begin
        check_eq({tag, "_idle_tx"},   32'(tr_tx[t]),   1);
        check_eq({tag, "_idle_busy"}, 32'(tr_busy[t]), 0);
        check_eq({tag, "_idle_done"}, 32'(tr_done[t]), 0);
        t++;
      end
    end
    check_eq({tag, "_frames_missing"}, 32'(exp_q.size()), 0);
    if (first_at >= 0) begin
      check_eq({tag, "_first_read"}, (pulse_pos.size() > 0) ? 32'(pulse_pos[0]) : 32'hffff_ffff,
               32'(first_at));
    end
  endtask

  initial begin
    logic [W-1:0] w0, w1;
    int           n;

    rst = 1'b1; en = 1'b1; fifo_empy = 1'b1; fifo_datout = '0;
    toggle = 1'b0; hold = 1'b0; tcnt = 0;

    step();
    check_eq("rst_tx", 32'(tx), 1);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_rclk", 32'(fifo_rclk), 0);
    check_eq("rst_done", 32'(done), 0);
    step();
    step();
    rst = 1'b0;

    // Empty FIFO with enable: line must stay idle.
    tcnt = 0;
    repeat (100) step();
    analyze("idle", -1);

    // Single word.
    push(3'b101); exp_q.push_back(3'b101);
    tcnt = 0;
    repeat (40) step();
    analyze("one", 0);
    check_eq("one_pulses", 32'(pulse_pos.size()), 1);

    // Back-to-back words.
    push(3'b011); push(3'b110);
    exp_q.push_back(3'b011); exp_q.push_back(3'b110);
    tcnt = 0;
    repeat (70) step();
    analyze("b2b", 0);
    check_eq("b2b_gap", (pulse_pos.size() >= 2) ? 32'(pulse_pos[1] - pulse_pos[0]) : 0, WIN);

    // Enable dropped during DATA of the first frame.
    w0 = W'($urandom); w1 = W'($urandom);
    push(w0); push(w1); exp_q.push_back(w0);
    tcnt = 0;
    repeat (9) step();
    en = 1'b0;
    repeat (50) step();
    analyze("en_drop", 0);
    check_eq("en_drop_left", 32'(fq.size()), 1);
    fq.delete(); fifo_empy = 1'b1; en = 1'b1;
    step();

    // Reset during data bit 1.
    w0 = W'($urandom);
    push(w0);
    tcnt = 0;
    repeat (12) step();
    check_eq("rst_pre_bit1", 32'(tr_tx[11]), 32'(w0[1]));
    rst = 1'b1;
    step();
    check_eq("midrst_tx", 32'(tx), 1);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_rclk", 32'(fifo_rclk), 0);
    check_eq("midrst_done", 32'(done), 0);
    rst = 1'b0;
    push(3'b100); exp_q.push_back(3'b100);
    tcnt = 0;
    repeat (40) step();
    analyze("post_rst", 0);

    // Read data scrambled outside the capture window.
    toggle = 1'b1;
    push(3'b010); exp_q.push_back(3'b010);
    tcnt = 0;
    repeat (40) step();
    analyze("toggle", 0);

    // Random bursts of queued words.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        w0 = W'($urandom);
        push(w0); exp_q.push_back(w0);
      end
      tcnt = 0;
      repeat (n * WIN + 10) step();
      analyze("rand", 0);
      check_eq("rand_pulses", 32'(pulse_pos.size()), 32'(n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
